kbd_ascii_decoder: RTL and testbench

Stateful PS/2 Set-2 keyboard decoder: consumes raw scan-code bytes from the PS/2 receiver, tracks make/break/extended prefixes, Shift and Caps Lock, and translates key presses into ASCII. Characters are buffered in a parametrised show-ahead FIFO with a valid/ready handshake. It sits between the PS/2 receiver and the processor's keyboard I/O port, replacing the stateless scan-code lookup.

---
 rtl/kbd_pkg.sv | 104 ++++++++++
 rtl/sync_fifo.sv | 77 +++++++
 rtl/kbd_ascii_decoder.sv | 171 +++++++++++++++++
 tb/tb_kbd_ascii_decoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// -----------------------------------------------------------------------------
// kbd_pkg
// Shared definitions for the PS/2 Set-2 keyboard decoder: scan-code and ASCII
// constants, the prefix FSM state type and the make-code translation function.
// No ports (package).
// -----------------------------------------------------------------------------
package kbd_pkg;

  // Prefix and special scan codes (Set 2)
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  // ASCII constants
  localparam logic [7:0] ASCII_NUL      = 8'h00;
  localparam logic [7:0] ASCII_BS       = 8'h08;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_SPACE    = 8'h20;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  // Prefix FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BREAK     = 2'd1,
    EXT       = 2'd2,
    EXT_BREAK = 2'd3
  } kbd_state_e;

  // Translation result: hit = code produces a character
  typedef struct packed {
    logic       hit;
    logic [7:0] chr;
  } xlat_t;

  // Translate a non-extended make code. 'shift' selects the digit-row symbols,
  // 'upper' selects uppercase letters. Letters are resolved to their uppercase
  // code first and lowered afterwards, so a nonzero 'letter' marks a letter key.
  function automatic xlat_t scan_to_ascii(input logic [7:0] code,
                                          input logic       shift,
                                          input logic       upper);
    xlat_t      r;
    logic [7:0] letter;
    r.hit  = 1'b1;
    r.chr  = ASCII_NUL;
    letter = ASCII_NUL;
    case (code)
      // digit row
      8'h45: r.chr = shift ? 8'h29 : 8'h30;
      8'h16: r.chr = shift ? 8'h21 : 8'h31;
      8'h1E: r.chr = shift ? 8'h40 : 8'h32;
      8'h26: r.chr = shift ? 8'h23 : 8'h33;
      8'h25: r.chr = shift ? 8'h24 : 8'h34;
      8'h2E: r.chr = shift ? 8'h25 : 8'h35;
      8'h36: r.chr = shift ? 8'h5E : 8'h36;
      8'h3D: r.chr = shift ? 8'h26 : 8'h37;
      8'h3E: r.chr = shift ? 8'h2A : 8'h38;
      8'h46: r.chr = shift ? 8'h28 : 8'h39;
      // letters
      8'h1C: letter = 8'h41;  // A
      8'h32: letter = 8'h42;  // B
      8'h21: letter = 8'h43;  // C
      8'h23: letter = 8'h44;  // D
      8'h24: letter = 8'h45;  // E
      8'h2B: letter = 8'h46;  // F
      8'h34: letter = 8'h47;  // G
      8'h33: letter = 8'h48;  // H
      8'h43: letter = 8'h49;  // I
      8'h3B: letter = 8'h4A;  // J
      8'h42: letter = 8'h4B;  // K
      8'h4B: letter = 8'h4C;  // L
      8'h3A: letter = 8'h4D;  // M
      8'h31: letter = 8'h4E;  // N
      8'h44: letter = 8'h4F;  // O
      8'h4D: letter = 8'h50;  // P
      8'h15: letter = 8'h51;  // Q
      8'h2D: letter = 8'h52;  // R
      8'h1B: letter = 8'h53;  // S
      8'h2C: letter = 8'h54;  // T
      8'h3C: letter = 8'h55;  // U
      8'h2A: letter = 8'h56;  // V
      8'h1D: letter = 8'h57;  // W
      8'h22: letter = 8'h58;  // X
      8'h35: letter = 8'h59;  // Y
      8'h1A: letter = 8'h5A;  // Z
      // whitespace / control, shift-independent
      SC_SPACE: r.chr = ASCII_SPACE;
      SC_ENTER: r.chr = ASCII_CR;
      SC_BKSP:  r.chr = ASCII_BS;
      default:  r.hit = 1'b0;
    endcase
    if (letter != ASCII_NUL) begin
      r.chr = upper ? letter : (letter + ASCII_CASE_OFS);
    end else begin
      r.chr = r.chr;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. The head entry is presented on rd_data whenever
// the FIFO is non-empty (zero when empty); rd_en pops it. Simultaneous read and
// write are supported, including a write into a full FIFO that is being popped
// in the same cycle. A write into a full FIFO without a pop is ignored.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   wr_en, wr_data  push request and data
//   rd_en           pop request (ignored when empty)
//   rd_data         head entry, 0 when empty
//   full, empty     occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_fire_s;
  logic             rd_fire_s;

  // Flags, handshake qualification and head-of-queue read
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_fire_s = rd_en && !empty;
    // a pop in the same cycle frees the slot the write needs
    wr_fire_s = wr_en && (!full || rd_fire_s);
    rd_data   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // Next-state for pointers and storage
  always_comb begin
    wr_ptr_d = wr_fire_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = rd_fire_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = (wr_fire_s && (wr_ptr_q[AW-1:0] == AW'(i))) ? wr_data : mem_q[i];
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/kbd_ascii_decoder.sv
// -----------------------------------------------------------------------------
// kbd_ascii_decoder
// Stateful PS/2 Set-2 decoder. Tracks break/extended prefixes, both Shift keys
// and Caps Lock, translates key presses to ASCII and buffers the characters in
// a show-ahead FIFO with a valid/ready handshake.
//
// Parameters:
//   FIFO_DEPTH    character buffer entries (power of two, >= 2)
//   LOWERCASE_EN  1: letter case follows Shift XOR Caps; 0: always uppercase
//
// Ports:
//   clk, reset                clock, synchronous active-high reset
//   scan_code, scan_valid     raw byte from the PS/2 receiver + strobe
//   ascii_data, ascii_valid   FIFO head (0 when empty) and non-empty flag
//   ascii_ready               consumer pops the head on valid && ready
//   fifo_full                 FIFO holds FIFO_DEPTH entries
//   overflow                  sticky: a character was dropped
//   shift_o, caps_o           modifier state
// -----------------------------------------------------------------------------
module kbd_ascii_decoder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter bit LOWERCASE_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] ascii_data,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       fifo_full,
  output logic       overflow,
  output logic       shift_o,
  output logic       caps_o
);

  kbd_state_e state_q, state_d;
  logic       shift_l_q, shift_l_d;
  logic       shift_r_q, shift_r_d;
  logic       shift_q, shift_d;
  logic       caps_q, caps_d;
  logic       caps_held_q, caps_held_d;
  logic       overflow_q, overflow_d;

  logic       upper_s;
  xlat_t      xlat_s;
  logic       push_s;
  logic [7:0] push_data_s;
  logic       pop_s;
  logic       fifo_empty_s;
  logic       fifo_full_s;
  logic [7:0] fifo_head_s;

  // Translation uses the modifier state as registered before this byte
  always_comb begin
    upper_s = !LOWERCASE_EN || (shift_q ^ caps_q);
    xlat_s  = scan_to_ascii(scan_code, shift_q, upper_s);
  end

  // Prefix FSM, modifier tracking and push generation
  always_comb begin
    state_d     = state_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    push_s      = 1'b0;
    push_data_s = ASCII_NUL;
    if (scan_valid) begin
      case (state_q)
        IDLE: begin
          if (scan_code == SC_BREAK) begin
            state_d = BREAK;
          end else if (scan_code == SC_EXT) begin
            state_d = EXT;
          end else begin
            state_d = IDLE;
            case (scan_code)
              SC_LSHIFT: shift_l_d = 1'b1;
              SC_RSHIFT: shift_r_d = 1'b1;
              SC_CAPS: begin
                // typematic repeats arrive with caps_held set and must not toggle
                caps_d      = caps_held_q ? caps_q : !caps_q;
                caps_held_d = 1'b1;
              end
              default: begin
                push_s      = xlat_s.hit;
                push_data_s = xlat_s.chr;
              end
            endcase
          end
        end
        EXT: begin
          if (scan_code == SC_BREAK) begin
            state_d = EXT_BREAK;
          end else begin
            state_d = IDLE;
            // keypad Enter is the only extended key that produces a character
            push_s      = (scan_code == SC_ENTER);
            push_data_s = ASCII_CR;
          end
        end
        BREAK: begin
          state_d = IDLE;
          case (scan_code)
            SC_LSHIFT: shift_l_d   = 1'b0;
            SC_RSHIFT: shift_r_d   = 1'b0;
            SC_CAPS:   caps_held_d = 1'b0;
            default:   caps_held_d = caps_held_q;
          endcase
        end
        EXT_BREAK: state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
    shift_d = shift_l_d || shift_r_d;
  end

  // Overflow is sticky; a push into a full FIFO survives only if a pop coincides
  always_comb begin
    pop_s      = !fifo_empty_s && ascii_ready;
    overflow_d = overflow_q || (push_s && fifo_full_s && !pop_s);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      shift_q     <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      shift_q     <= shift_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_s),
    .wr_data (push_data_s),
    .rd_en   (ascii_ready),
    .rd_data (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign ascii_data  = fifo_head_s;
  assign ascii_valid = !fifo_empty_s;
  assign fifo_full   = fifo_full_s;
  assign overflow    = overflow_q;
  assign shift_o     = shift_q;
  assign caps_o      = caps_q;

endmodule

// File: tb/tb_kbd_ascii_decoder.sv
// -----------------------------------------------------------------------------
// tb_kbd_ascii_decoder
// Directed bench for kbd_ascii_decoder. Two instances share all inputs: one in
// lowercase mode, one in legacy uppercase mode. Inputs change on the falling
// edge, outputs are sampled on the falling edge after the consuming rising edge.
// -----------------------------------------------------------------------------
module tb_kbd_ascii_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       ascii_ready;

  logic [7:0] ascii_data;
  logic       ascii_valid;
  logic       fifo_full;
  logic       overflow;
  logic       shift_o;
  logic       caps_o;

  logic [7:0] lg_ascii_data;
  logic       lg_ascii_valid;
  logic       lg_fifo_full;
  logic       lg_overflow;
  logic       lg_shift_o;
  logic       lg_caps_o;

  int checks = 0;
  int errors = 0;

  kbd_ascii_decoder #(.FIFO_DEPTH(8), .LOWERCASE_EN(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .ascii_data  (ascii_data),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .shift_o     (shift_o),
    .caps_o      (caps_o)
  );

  kbd_ascii_decoder #(.FIFO_DEPTH(8), .LOWERCASE_EN(1'b0)) dut_legacy (
    .clk         (clk),
    .reset       (reset),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .ascii_data  (lg_ascii_data),
    .ascii_valid (lg_ascii_valid),
    .ascii_ready (ascii_ready),
    .fifo_full   (lg_fifo_full),
    .overflow    (lg_overflow),
    .shift_o     (lg_shift_o),
    .caps_o      (lg_caps_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Strobe one scan byte; returns at the next falling edge
  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    scan_code  = 8'h00;
  endtask

  // Check the head of both FIFOs, then pop it for one cycle
  task automatic pop_expect(input string tag, input logic [7:0] exp, input logic [7:0] exp_lg);
    check_eq({tag, "_valid"}, 8'(ascii_valid), 8'h01);
    check_eq({tag, "_data"}, ascii_data, exp);
    check_eq({tag, "_legacy"}, lg_ascii_data, exp_lg);
    ascii_ready = 1'b1;
    @(negedge clk);
    ascii_ready = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    scan_code   = 8'h00;
    scan_valid  = 1'b0;
    ascii_ready = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check_eq("rst_valid", 8'(ascii_valid), 8'h00);
    check_eq("rst_data", ascii_data, 8'h00);
    check_eq("rst_full", 8'(fifo_full), 8'h00);
    check_eq("rst_ovf", 8'(overflow), 8'h00);
    check_eq("rst_shift", 8'(shift_o), 8'h00);
    check_eq("rst_caps", 8'(caps_o), 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // press/release A: one character, visible one cycle after the make
    send(8'h1C);
    check_eq("a_latency", 8'(ascii_valid), 8'h01);
    send(8'hF0);
    send(8'h1C);
    pop_expect("a", 8'h61, 8'h41);
    check_eq("a_single", 8'(ascii_valid), 8'h00);

    // Shift + 2 -> '@'
    send(8'h12);
    check_eq("lshift_held", 8'(shift_o), 8'h01);
    send(8'h1E);
    send(8'hF0);
    send(8'h1E);
    check_eq("lshift_still", 8'(shift_o), 8'h01);
    send(8'hF0);
    send(8'h12);
    check_eq("lshift_rel", 8'(shift_o), 8'h00);
    pop_expect("at", 8'h40, 8'h40);
    check_eq("at_single", 8'(ascii_valid), 8'h00);

    // right Shift + 1 -> '!'
    send(8'h59);
    send(8'h16);
    send(8'hF0);
    send(8'h59);
    check_eq("rshift_rel", 8'(shift_o), 8'h00);
    pop_expect("bang", 8'h21, 8'h21);

    // Caps with typematic repeat toggles once
    send(8'h58);
    send(8'h58);
    send(8'hF0);
    send(8'h58);
    check_eq("caps_on", 8'(caps_o), 8'h01);
    send(8'h1C);
    pop_expect("caps_a", 8'h41, 8'h41);
    send(8'h12);
    send(8'h1C);
    send(8'hF0);
    send(8'h12);
    pop_expect("caps_shift_a", 8'h61, 8'h41);
    send(8'h58);
    send(8'hF0);
    send(8'h58);
    check_eq("caps_off", 8'(caps_o), 8'h00);

    // extended keys: keypad Enter emits CR, arrow emits nothing
    send(8'hE0);
    send(8'h5A);
    pop_expect("kp_enter", 8'h0D, 8'h0D);
    send(8'hE0);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check_eq("arrow_none", 8'(ascii_valid), 8'h00);
    check_eq("arrow_idle", 8'(dut.state_q), 8'(kbd_pkg::IDLE));
    send(8'h1C);
    pop_expect("after_arrow", 8'h61, 8'h41);

    // space, backspace, unmapped F1, digit 0
    send(8'h29);
    send(8'h66);
    send(8'h05);
    send(8'h45);
    pop_expect("space", 8'h20, 8'h20);
    pop_expect("bksp", 8'h08, 8'h08);
    pop_expect("zero", 8'h30, 8'h30);
    check_eq("unmapped_none", 8'(ascii_valid), 8'h00);

    // fill, overflow, then simultaneous push+pop while full
    for (int i = 0; i < 8; i++) send(8'h16);
    check_eq("fill8_full", 8'(fifo_full), 8'h01);
    check_eq("fill8_ovf", 8'(overflow), 8'h00);
    send(8'h16);
    check_eq("fill9_full", 8'(fifo_full), 8'h01);
    check_eq("fill9_ovf", 8'(overflow), 8'h01);
    check_eq("fill9_head", ascii_data, 8'h31);
    scan_code   = 8'h1E;
    scan_valid  = 1'b1;
    ascii_ready = 1'b1;
    @(negedge clk);
    scan_valid  = 1'b0;
    ascii_ready = 1'b0;
    check_eq("pushpop_full", 8'(fifo_full), 8'h01);
    for (int i = 0; i < 7; i++) pop_expect("drain", 8'h31, 8'h31);
    pop_expect("drain_last", 8'h32, 8'h32);
    check_eq("drain_empty", 8'(ascii_valid), 8'h00);
    check_eq("drain_notfull", 8'(fifo_full), 8'h00);
    check_eq("ovf_sticky", 8'(overflow), 8'h01);

    // reset in the middle of an extended sequence
    send(8'h58);
    send(8'h12);
    send(8'h1C);
    send(8'hE0);
    check_eq("pre_rst_ext", 8'(dut.state_q), 8'(kbd_pkg::EXT));
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", 8'(ascii_valid), 8'h00);
    check_eq("mid_rst_data", ascii_data, 8'h00);
    check_eq("mid_rst_full", 8'(fifo_full), 8'h00);
    check_eq("mid_rst_ovf", 8'(overflow), 8'h00);
    check_eq("mid_rst_shift", 8'(shift_o), 8'h00);
    check_eq("mid_rst_caps", 8'(caps_o), 8'h00);
    check_eq("mid_rst_state", 8'(dut.state_q), 8'(kbd_pkg::IDLE));
    reset = 1'b0;
    send(8'h5A);
    check_eq("post_rst_state", 8'(dut.state_q), 8'(kbd_pkg::IDLE));
    pop_expect("post_rst_enter", 8'h0D, 8'h0D);
    send(8'h1C);
    pop_expect("post_rst_a", 8'h61, 8'h41);
    check_eq("post_rst_empty", 8'(ascii_valid), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
